universal_counter_nd: RTL and testbench



---
 rtl/ucnt_pkg.sv | 18 +
 rtl/ucnt_debounce.sv | 58 +++++
 rtl/universal_counter_nd.sv | 124 ++++++++++++
 tb/tb_universal_counter_nd.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ucnt_pkg.sv
// Shared types and the active-low 7-segment code table for the universal counter.
package ucnt_pkg;

   typedef logic [3:0] digit_t;

   // Index = digit value 0..F; bit 7 is DP (kept off), bits 6:0 are g..a.
   localparam logic [7:0] SEG7_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] seg7_encode(input digit_t d);
      return SEG7_LUT[d];
   endfunction

endpackage

// File: rtl/ucnt_debounce.sv
// Push-button front end: 2-FF synchroniser, stability counter and press (1->0) pulse.
module ucnt_debounce #(
   parameter int P_DEBOUNCE_CYCLES = 2**16
) (
   input  logic CLK1,
   input  logic RST,
   input  logic BTN_N,
   output logic LEVEL,
   output logic PRESS_PULSE
);

   localparam int CNT_W = $clog2(P_DEBOUNCE_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(P_DEBOUNCE_CYCLES);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The level flips on the cycle after the counter has seen P disagreeing samples,
   // and only if the synchronised input still disagrees on that cycle.
   always_comb begin
      sync1_d = BTN_N;
      sync2_d = sync1_q;
      level_d = level_q;
      pulse_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LIM) begin
            level_d = sync2_q;
            pulse_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK1) begin
      if (RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign LEVEL       = level_q;
   assign PRESS_PULSE = pulse_q;

endmodule

// File: rtl/universal_counter_nd.sv
// N-digit base-B up/down counter with debounced step button and registered 7-seg output.
// Define UCNT_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module universal_counter_nd
   import ucnt_pkg::*;
#(
   parameter int P_BASE_NUMBER     = 7,
   parameter int P_DIGITS          = 2,
   parameter int P_DEBOUNCE_CYCLES = 2**16
) (
   input  logic                    CLK1,
   input  logic                    RST,
   input  logic                    BTN_N,
   input  logic                    DIR,
   input  logic                    EN,
   input  logic                    CLR,
   output logic [4*P_DIGITS-1:0]   COUNT,
   output logic [8*P_DIGITS-1:0]   HEX,
   output logic                    CARRY,
   output logic                    OVF
);

   localparam digit_t DIGIT_MAX = digit_t'(P_BASE_NUMBER - 1);

   logic                  press_level;
   logic                  press_pulse;
   logic                  step;
   logic [4*P_DIGITS-1:0] stepped;
   logic [P_DIGITS:0]     cy;

   logic [4*P_DIGITS-1:0] count_q, count_d;
   logic [8*P_DIGITS-1:0] hex_q, hex_d;
   logic                  carry_q, carry_d;
   logic                  ovf_q, ovf_d;

   ucnt_debounce #(
      .P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)
   ) u_debounce (
      .CLK1        (CLK1),
      .RST         (RST),
      .BTN_N       (BTN_N),
      .LEVEL       (press_level),
      .PRESS_PULSE (press_pulse)
   );

   assign step = press_pulse & ~press_level & EN;

   function automatic logic [8*P_DIGITS-1:0] hex_encode(input logic [4*P_DIGITS-1:0] cnt);
      logic [8*P_DIGITS-1:0] res;
`ifdef UCNT_LEADING_ZERO_BLANK_EN
      logic zero_run;
      zero_run = 1'b1;
`endif
      res = '0;
      for (int i = P_DIGITS - 1; i >= 0; i--) begin
         res[8*i+:8] = seg7_encode(cnt[4*i+:4]);
`ifdef UCNT_LEADING_ZERO_BLANK_EN
         zero_run = zero_run & (cnt[4*i+:4] == 4'd0);
         if (i != 0 && zero_run) res[8*i+:8] = SEG_BLANK;
`endif
      end
      return res;
   endfunction

   // Ripple the +1/-1 through the digit chain; cy[P_DIGITS] set means the whole count wrapped.
   always_comb begin
      stepped = count_q;
      cy      = '0;
      cy[0]   = 1'b1;
      for (int i = 0; i < P_DIGITS; i++) begin
         if (cy[i]) begin
            if (!DIR) begin
               if (count_q[4*i+:4] == DIGIT_MAX) begin
                  stepped[4*i+:4] = 4'd0;
                  cy[i+1]         = 1'b1;
               end else begin
                  stepped[4*i+:4] = count_q[4*i+:4] + 4'd1;
               end
            end else begin
               if (count_q[4*i+:4] == 4'd0) begin
                  stepped[4*i+:4] = DIGIT_MAX;
                  cy[i+1]         = 1'b1;
               end else begin
                  stepped[4*i+:4] = count_q[4*i+:4] - 4'd1;
               end
            end
         end
      end
   end

   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      ovf_d   = ovf_q;
      if (CLR) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (step) begin
         count_d = stepped;
         carry_d = cy[P_DIGITS];
         ovf_d   = ovf_q | cy[P_DIGITS];
      end
      hex_d = hex_encode(count_q);
   end

   always_ff @(posedge CLK1) begin
      if (RST) begin
         count_q <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         hex_q   <= hex_encode('0);
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         hex_q   <= hex_d;
      end
   end

   assign COUNT = count_q;
   assign HEX   = hex_q;
   assign CARRY = carry_q;
   assign OVF   = ovf_q;

endmodule

// File: tb/tb_universal_counter_nd.sv
// Scoreboard bench for universal_counter_nd (base 7, 2 digits, debounce 4) with a value-level model.
module tb_universal_counter_nd;

   localparam int B = 7;
   localparam int N = 2;
   localparam int P = 4;
   localparam int M = B * B;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_n = 1'b1;
   logic dir = 1'b0;
   logic en = 1'b1;
   logic clr = 1'b0;
   logic [4*N-1:0] count;
   logic [8*N-1:0] hex;
   logic carry;
   logic ovf;

   universal_counter_nd #(
      .P_BASE_NUMBER(B),
      .P_DIGITS(N),
      .P_DEBOUNCE_CYCLES(P)
   ) dut (
      .CLK1  (clk),
      .RST   (rst),
      .BTN_N (btn_n),
      .DIR   (dir),
      .EN    (en),
      .CLR   (clr),
      .COUNT (count),
      .HEX   (hex),
      .CARRY (carry),
      .OVF   (ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   logic [7:0] seg_tab [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   typedef struct {
      logic [4*N-1:0] count;
      logic           carry;
      logic           ovf;
      logic [8*N-1:0] hex;
      int             cyc;
   } exp_t;

   exp_t exp_q[$];

   int mv = 0;
   bit movf = 1'b0;
   bit mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [4*N-1:0] pack(input int v);
      logic [4*N-1:0] r;
      int t;
      t = v;
      for (int i = 0; i < N; i++) begin
         r[4*i+:4] = 4'(t % B);
         t = t / B;
      end
      return r;
   endfunction

   function automatic logic [8*N-1:0] hexof(input int v);
      logic [8*N-1:0] r;
      int t;
      int pw;
      t = v;
      pw = 1;
      for (int i = 0; i < N; i++) begin
         r[8*i+:8] = seg_tab[t % B];
`ifdef UCNT_LEADING_ZERO_BLANK_EN
         if (i > 0 && v < pw) r[8*i+:8] = 8'hFF;
`endif
         t = t / B;
         pw = pw * B;
      end
      return r;
   endfunction

   task automatic push(input bit cw, input int at);
      exp_t e;
      e.count = pack(mv);
      e.carry = cw;
      e.ovf   = movf;
      e.hex   = hexof(mv);
      e.cyc   = at;
      exp_q.push_back(e);
   endtask

   // One press: low for 'low' sampled edges, then high. Optional CLR on the step-pulse cycle.
   task automatic press(input bit d, input bit e_n, input int low, input int high, input bit c);
      int k;
      bit wrap;
      @(negedge clk);
      dir = d;
      en = e_n;
      btn_n = 1'b0;
      k = cyc;
      if (c) begin
         if (mv != 0 || movf) begin
            mv = 0;
            movf = 1'b0;
            push(1'b0, k + P + 4);
         end
      end else if (low >= P + 2 && e_n) begin
         wrap = d ? (mv == 0) : (mv == M - 1);
         mv = d ? (mv + M - 1) % M : (mv + 1) % M;
         if (wrap) movf = 1'b1;
         push(wrap, k + P + 4);
      end
      for (int i = 1; i <= low + high; i++) begin
         @(negedge clk);
         if (i == low) btn_n = 1'b1;
         clr = c && (i == P + 3);
      end
      clr = 1'b0;
   endtask

   task automatic rst_mid_press();
      int k;
      @(negedge clk);
      dir = 1'b0;
      en = 1'b1;
      btn_n = 1'b0;
      k = cyc;
      if (mv != 0 || movf) begin
         mv = 0;
         movf = 1'b0;
         push(1'b0, k + 4);
      end
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i == 3) rst = 1'b1;
         if (i == 4) rst = 1'b0;
         if (i == 6) btn_n = 1'b1;
      end
   endtask

   function automatic int rand_low();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(3, 4));
      return int'($urandom_range(6, 10));
   endfunction

   // Monitor: any visible change (COUNT/OVF) or a CARRY pulse consumes one expectation.
   initial begin
      logic [4*N-1:0] prev_count;
      logic           prev_ovf;
      exp_t e;
      prev_count = '0;
      prev_ovf = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && (count !== prev_count || ovf !== prev_ovf || carry !== 1'b0)) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_update: count=%0h carry=%0b ovf=%0b, want no change (cycle %0d)",
                        count, carry, ovf, cyc);
            end else begin
               e = exp_q.pop_front();
               check("update_cycle", 32'(cyc), 32'(e.cyc));
               check("count", 32'(count), 32'(e.count));
               check("carry", 32'(carry), 32'(e.carry));
               check("ovf", 32'(ovf), 32'(e.ovf));
               @(negedge clk);
               check("hex", 32'(hex), 32'(e.hex));
               check("carry_one_cycle", 32'(carry), 32'd0);
            end
         end
         prev_count = count;
         prev_ovf = ovf;
      end
   end

   initial begin
      repeat (10) @(negedge clk);
      check("rst_count", 32'(count), 32'h00);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
`ifdef UCNT_LEADING_ZERO_BLANK_EN
      check("rst_hex", 32'(hex), 32'hFFC0);
`else
      check("rst_hex", 32'(hex), 32'hC0C0);
`endif
      rst = 1'b0;
      mon_en = 1'b1;

      repeat (3) press(1'b0, 1'b1, 10, 10, 1'b0);
      check("three_count", 32'(count), 32'h03);
      check("three_hex0", 32'(hex[7:0]), 32'hB0);

      repeat (45) press(1'b0, 1'b1, int'($urandom_range(6, 10)), int'($urandom_range(6, 10)), 1'b0);
      check("max_count", 32'(count), 32'h66);
      check("max_hex", 32'(hex), 32'h8282);
      check("max_ovf", 32'(ovf), 32'd0);

      press(1'b0, 1'b1, 10, 10, 1'b0);
      check("wrap_up_count", 32'(count), 32'h00);
      check("wrap_up_ovf", 32'(ovf), 32'd1);

      press(1'b0, 1'b1, 3, 10, 1'b0);
      check("glitch_count", 32'(count), 32'h00);

      press(1'b1, 1'b1, 10, 10, 1'b0);
      check("wrap_down_count", 32'(count), 32'h66);
      press(1'b1, 1'b1, 10, 10, 1'b0);
      check("down_count", 32'(count), 32'h65);

      press(1'b1, 1'b1, 10, 10, 1'b1);
      check("clr_count", 32'(count), 32'h00);
      check("clr_ovf", 32'(ovf), 32'd0);

      repeat (2) press(1'b0, 1'b1, 8, 8, 1'b0);
      check("pre_rst_count", 32'(count), 32'h02);
      rst_mid_press();
      check("rst_mid_count", 32'(count), 32'h00);

      press(1'b0, 1'b0, 10, 10, 1'b0);
      check("en_off_count", 32'(count), 32'h00);

      repeat (40) press(1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0), rand_low(),
                        int'($urandom_range(6, 10)), ($urandom_range(0, 7) == 0));
      check("random_end_count", 32'(count), 32'(pack(mv)));

      repeat (20) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
